// File: rtl/pc_cfr_pd_mp.sv
// pc_cfr_pd_mp: multi-phase peak detector for the peak-cancellation CFR path.
// Finds local maxima of the per-cycle maximum envelope across NUM_PHASES polar
// samples, qualifies them against a detection threshold and a minimum peak
// spacing, and emits the saturated clipping excess with its theta and phase.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   data_valid, data_r,      NUM_PHASES packed magnitudes / angles per clock,
//   data_theta               phase 0 earliest in time
//   peak_r/theta/phase/valid registered peak report, one-cycle strobe
//   ctrl_enable              detector enable; low acts as a synchronous clear
//   ctrl_pd_threshold        detection threshold (strict greater-than)
//   ctrl_clipping_threshold  subtracted from the peak magnitude
//   ctrl_min_spacing         minimum clocks between emitted peaks, 0 = none
//   stat_peak_count/drop     status counters
//
// Optional feature: define PC_CFR_PD_MP_STAT_EN to build the status counters;
// otherwise both stat ports are tied to 0.
module pc_cfr_pd_mp #(
   parameter int ITERATIONS    = 7,
   parameter int DATA_WIDTH    = 16,
   parameter int NUM_PHASES    = 4,
   parameter int PHASE_WIDTH   = (NUM_PHASES > 1 ? $clog2(NUM_PHASES) : 1),
   parameter int SPACING_WIDTH = 8
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   data_valid,
   input  logic [NUM_PHASES*(DATA_WIDTH+1)-1:0]   data_r,
   input  logic [NUM_PHASES*(ITERATIONS+1)-1:0]   data_theta,
   output logic [DATA_WIDTH:0]                    peak_r,
   output logic [ITERATIONS:0]                    peak_theta,
   output logic [PHASE_WIDTH-1:0]                 peak_phase,
   output logic                                   peak_valid,
   input  logic                                   ctrl_enable,
   input  logic [DATA_WIDTH:0]                    ctrl_pd_threshold,
   input  logic [DATA_WIDTH:0]                    ctrl_clipping_threshold,
   input  logic [SPACING_WIDTH-1:0]               ctrl_min_spacing,
   output logic [31:0]                            stat_peak_count,
   output logic [15:0]                            stat_peak_drop
);

   localparam int unsigned RW = DATA_WIDTH + 1;
   localparam int unsigned TW = ITERATIONS + 1;

   typedef enum logic {S_NEG, S_POS} state_t;

   state_t                   state;
   logic [RW-1:0]            state_max;
   logic [TW-1:0]            state_theta;
   logic [PHASE_WIDTH-1:0]   state_phase;

   logic                     cand_pre;
   logic [RW-1:0]            cand_r;
   logic [TW-1:0]            cand_theta;
   logic [PHASE_WIDTH-1:0]   cand_phase;

   logic [SPACING_WIDTH-1:0] space_cnt;

   logic [RW-1:0]            m_r;
   logic [TW-1:0]            m_theta;
   logic [PHASE_WIDTH-1:0]   m_phase;
   logic                     rise;
   logic                     qual;
   logic                     emit;

   // Cycle maximum; >= lets a later (higher-index) phase win a tie.
   always_comb begin
      m_r     = data_r[0 +: RW];
      m_theta = data_theta[0 +: TW];
      m_phase = '0;
      for (int p = 1; p < NUM_PHASES; p++) begin
         if (data_r[p*RW +: RW] >= m_r) begin
            m_r     = data_r[p*RW +: RW];
            m_theta = data_theta[p*TW +: TW];
            m_phase = PHASE_WIDTH'(p);
         end
      end
   end

   assign rise = (m_r >= state_max);
   assign qual = cand_pre && (cand_r > ctrl_pd_threshold);
   assign emit = qual && (space_cnt == '0);

   // Stage 1: rise/fall tracker; a fall after a rise latches the old maximum.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_NEG;
         state_max   <= '0;
         state_theta <= '0;
         state_phase <= '0;
         cand_pre    <= 1'b0;
         cand_r      <= '0;
         cand_theta  <= '0;
         cand_phase  <= '0;
      end else if (!ctrl_enable) begin
         state       <= S_NEG;
         state_max   <= '0;
         state_theta <= '0;
         state_phase <= '0;
         cand_pre    <= 1'b0;
         cand_r      <= '0;
         cand_theta  <= '0;
         cand_phase  <= '0;
      end else if (data_valid) begin
         state       <= rise ? S_POS : S_NEG;
         state_max   <= m_r;
         state_theta <= m_theta;
         state_phase <= m_phase;
         cand_pre    <= (state == S_POS) && !rise;
         if ((state == S_POS) && !rise) begin
            cand_r     <= state_max;
            cand_theta <= state_theta;
            cand_phase <= state_phase;
         end else begin
            cand_r     <= '0;
            cand_theta <= '0;
            cand_phase <= '0;
         end
      end else begin
         cand_pre <= 1'b0;
      end
   end

   // Stage 2: threshold + spacing qualification and registered peak report.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         space_cnt  <= '0;
         peak_valid <= 1'b0;
         peak_r     <= '0;
         peak_theta <= '0;
         peak_phase <= '0;
      end else if (!ctrl_enable) begin
         space_cnt  <= '0;
         peak_valid <= 1'b0;
         peak_r     <= '0;
         peak_theta <= '0;
         peak_phase <= '0;
      end else begin
         if (emit)
            space_cnt <= ctrl_min_spacing;
         else if (space_cnt != '0)
            space_cnt <= space_cnt - 1'b1;
         peak_valid <= emit;
         if (emit) begin
            peak_r     <= (cand_r > ctrl_clipping_threshold) ?
                          (cand_r - ctrl_clipping_threshold) : '0;
            peak_theta <= cand_theta;
            peak_phase <= cand_phase;
         end else begin
            peak_r     <= '0;
            peak_theta <= '0;
            peak_phase <= '0;
         end
      end
   end

`ifdef PC_CFR_PD_MP_STAT_EN
   logic [31:0] cnt_q;
   logic [15:0] drop_q;

   // Saturating emitted / spacing-dropped peak counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         drop_q <= '0;
      end else if (!ctrl_enable) begin
         cnt_q  <= '0;
         drop_q <= '0;
      end else begin
         if (emit && (cnt_q != '1))
            cnt_q <= cnt_q + 1'b1;
         if (qual && (space_cnt != '0) && (drop_q != '1))
            drop_q <= drop_q + 1'b1;
      end
   end

   assign stat_peak_count = cnt_q;
   assign stat_peak_drop  = drop_q;
`else
   assign stat_peak_count = '0;
   assign stat_peak_drop  = '0;
`endif

endmodule

// File: tb/tb_pc_cfr_pd_mp.sv
// Testbench for pc_cfr_pd_mp: directed and random stimulus, expected peaks
// produced by a local-maximum reference model and checked by a monitor.
module tb_pc_cfr_pd_mp;
   localparam int NP = 4;
   localparam int DW = 16;
   localparam int IT = 7;
   localparam int RW = DW + 1;
   localparam int TW = IT + 1;
   localparam int PW = 2;
   localparam int SW = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              data_valid;
   logic [NP*RW-1:0]  data_r;
   logic [NP*TW-1:0]  data_theta;
   logic [RW-1:0]     peak_r;
   logic [TW-1:0]     peak_theta;
   logic [PW-1:0]     peak_phase;
   logic              peak_valid;
   logic              ctrl_enable;
   logic [RW-1:0]     ctrl_pd_threshold;
   logic [RW-1:0]     ctrl_clipping_threshold;
   logic [SW-1:0]     ctrl_min_spacing;
   logic [31:0]       stat_peak_count;
   logic [15:0]       stat_peak_drop;

   always #5 clk = ~clk;

   pc_cfr_pd_mp #(.ITERATIONS(IT), .DATA_WIDTH(DW), .NUM_PHASES(NP),
                  .PHASE_WIDTH(PW), .SPACING_WIDTH(SW)) dut (
      .clk(clk), .rst(rst), .data_valid(data_valid), .data_r(data_r),
      .data_theta(data_theta), .peak_r(peak_r), .peak_theta(peak_theta),
      .peak_phase(peak_phase), .peak_valid(peak_valid),
      .ctrl_enable(ctrl_enable), .ctrl_pd_threshold(ctrl_pd_threshold),
      .ctrl_clipping_threshold(ctrl_clipping_threshold),
      .ctrl_min_spacing(ctrl_min_spacing),
      .stat_peak_count(stat_peak_count), .stat_peak_drop(stat_peak_drop));

   typedef struct packed {
      logic [31:0]   edge_n;
      logic [RW-1:0] r;
      logic [TW-1:0] th;
      logic [PW-1:0] ph;
   } exp_t;

   typedef struct packed {
      logic [RW-1:0] m;
      logic [TW-1:0] th;
      logic [PW-1:0] ph;
   } samp_t;

   exp_t  sbq[$];
   samp_t hist[$];
   int    n_cmp = 0;
   int    n_bad = 0;
   int    cyc = 0;
   bit    started = 0;
   bit    pend;
   samp_t pend_s;
   bit    have_emit;
   int    last_emit_edge;
   int    last_s;
   int    mdl_cnt;
   int    mdl_drop;
   exp_t  mon_e;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void model_clear();
      hist.delete();
      pend      = 0;
      have_emit = 0;
      mdl_cnt   = 0;
      mdl_drop  = 0;
   endfunction

   // Largest magnitude of the cycle; among equals the latest phase wins.
   function automatic samp_t cycmax();
      samp_t s;
      logic [RW-1:0] best = '0;
      for (int p = 0; p < NP; p++)
         if (data_r[p*RW +: RW] > best) best = data_r[p*RW +: RW];
      s = '0;
      for (int p = NP - 1; p >= 0; p--) begin
         if (data_r[p*RW +: RW] == best) begin
            s.m  = best;
            s.th = data_theta[p*TW +: TW];
            s.ph = PW'(p);
            break;
         end
      end
      return s;
   endfunction

   // One clock edge of the reference: a sample is a peak once the next valid
   // sample is strictly lower and it was not itself below its predecessor.
   function automatic void model_step();
      samp_t cur;
      exp_t  e;
      if (!ctrl_enable) begin
         model_clear();
         return;
      end
      if (pend && (pend_s.m > ctrl_pd_threshold)) begin
         if (!have_emit || (cyc - last_emit_edge) > last_s) begin
            e.edge_n = 32'(cyc);
            e.r  = (pend_s.m > ctrl_clipping_threshold) ? pend_s.m - ctrl_clipping_threshold : '0;
            e.th = pend_s.th;
            e.ph = pend_s.ph;
            sbq.push_back(e);
            have_emit      = 1;
            last_emit_edge = cyc;
            last_s         = int'(ctrl_min_spacing);
            mdl_cnt++;
         end else begin
            mdl_drop++;
         end
      end
      pend = 0;
      if (data_valid) begin
         cur = cycmax();
         if (hist.size() >= 1 && cur.m < hist[$].m &&
             (hist.size() == 1 || hist[$].m >= hist[$-1].m)) begin
            pend   = 1;
            pend_s = hist[$];
         end
         hist.push_back(cur);
         if (hist.size() > 2) void'(hist.pop_front());
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      cyc++;
      model_step();
      @(negedge clk);
   endtask

   // Drive one sample set whose cycle maximum is m on phase ph with angle th.
   task automatic set_m(input int m, input int ph, input int th);
      data_valid = 1'b1;
      for (int p = 0; p < NP; p++) begin
         data_theta[p*TW +: TW] = TW'($urandom);
         if (p == ph)
            data_r[p*RW +: RW] = RW'(m);
         else
            data_r[p*RW +: RW] = (m > 0) ? RW'($urandom_range(m - 1, 0)) : '0;
      end
      data_theta[ph*TW +: TW] = TW'(th);
   endtask

   task automatic seq(input int m);
      set_m(m, int'($urandom_range(NP - 1, 0)), int'($urandom_range(255, 0)));
      tick();
   endtask

   task automatic idle(input int n);
      data_valid = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check_stats();
`ifdef PC_CFR_PD_MP_STAT_EN
      chk("stat_count", 64'(stat_peak_count), 64'(mdl_cnt));
      chk("stat_drop", 64'(stat_peak_drop), 64'(mdl_drop));
`else
      chk("stat_count_tied", 64'(stat_peak_count), 64'd0);
      chk("stat_drop_tied", 64'(stat_peak_drop), 64'd0);
`endif
   endtask

   // Monitor: pops the scoreboard whenever the DUT strobes a peak.
   always @(negedge clk) begin
      if (started && !rst) begin
         if (peak_valid) begin
            if (sbq.size() == 0) begin
               chk("unexpected_peak", 64'(peak_valid), 64'd0);
            end else begin
               mon_e = sbq.pop_front();
               chk("peak_edge", 64'(cyc), 64'(mon_e.edge_n));
               chk("peak_r", 64'(peak_r), 64'(mon_e.r));
               chk("peak_theta", 64'(peak_theta), 64'(mon_e.th));
               chk("peak_phase", 64'(peak_phase), 64'(mon_e.ph));
            end
         end else begin
            chk("idle_zero", 64'({peak_r, peak_theta, peak_phase}), 64'd0);
            if (sbq.size() > 0 && int'(sbq[0].edge_n) <= cyc) begin
               mon_e = sbq.pop_front();
               chk("missing_peak", 64'(peak_valid), 64'd1);
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      data_valid = 1'b0;
      data_r = '0;
      data_theta = '0;
      ctrl_enable = 1'b1;
      ctrl_pd_threshold = RW'(1000);
      ctrl_clipping_threshold = RW'(800);
      ctrl_min_spacing = '0;
      model_clear();
      repeat (3) @(negedge clk);
      chk("reset_outputs", 64'({peak_valid, peak_r, peak_theta, peak_phase}), 64'd0);
      check_stats();
      rst = 1'b0;
      started = 1;

      // Basic peak: 500, 1200 (phase 2, theta 0x15), 900.
      seq(500);
      set_m(1200, 2, 'h15); tick();
      seq(900);
      seq(100); seq(100);

      // Threshold edges: 950 and 1000 rejected, 1001 with clip 1200 gives 0.
      seq(500); seq(950); seq(100);
      seq(500); seq(1000); seq(100);
      ctrl_clipping_threshold = RW'(1200);
      seq(500); seq(1001); seq(100); seq(100);
      ctrl_clipping_threshold = RW'(800);

      // Tie of 700 on phases 1 and 3: phase 3 reported.
      seq(300);
      set_m(700, 1, 'h21);
      data_r[0*RW +: RW] = RW'(100);
      data_r[2*RW +: RW] = RW'(200);
      data_r[3*RW +: RW] = RW'(700);
      data_theta[3*TW +: TW] = TW'('h33);
      tick();
      seq(100); seq(100);

      // Spacing 4: peaks 3 then 6 clocks apart; the middle one is dropped.
      ctrl_enable = 1'b0; tick();
      ctrl_enable = 1'b1;
      ctrl_min_spacing = SW'(4);
      seq(100); seq(1500); seq(100);
      seq(100); seq(1600); seq(100);
      seq(100); seq(100); seq(100); seq(100); seq(1700); seq(100);
      idle(3);
      check_stats();
`ifdef PC_CFR_PD_MP_STAT_EN
      chk("spacing_count", 64'(stat_peak_count), 64'd2);
      chk("spacing_drop", 64'(stat_peak_drop), 64'd1);
`endif
      ctrl_min_spacing = '0;

      // Rising run broken by a 5-cycle valid gap, then a fall.
      seq(100); seq(1200); seq(1500);
      idle(5);
      seq(800); seq(100);

      // Reset mid-rise: immediate zero outputs, no stale peak afterwards.
      seq(100); seq(1300);
      #2 rst = 1'b1;
      model_clear();
      #1 chk("async_reset", 64'({peak_valid, peak_r, stat_peak_count}), 64'd0);
      @(posedge clk); cyc++;
      @(negedge clk); rst = 1'b0;
      seq(200); seq(100); seq(1400); seq(200); seq(100);

      // Enable dropped with a candidate pending; spacing restarts cleanly.
      ctrl_min_spacing = SW'(8);
      seq(100); seq(1500); seq(200);
      seq(1600); seq(300);
      ctrl_enable = 1'b0; tick();
      ctrl_enable = 1'b1;
      seq(1500); seq(200); seq(100);
      idle(2);

      // Randomized traffic with occasional control changes and clears.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(99, 0) == 0) ctrl_min_spacing = SW'($urandom_range(5, 0));
         if ($urandom_range(199, 0) == 0) ctrl_pd_threshold = RW'($urandom_range(1500, 500));
         if ($urandom_range(199, 0) == 0) ctrl_clipping_threshold = RW'($urandom_range(1500, 0));
         ctrl_enable = ($urandom_range(99, 0) != 0);
         data_valid  = ($urandom_range(9, 0) < 8);
         for (int p = 0; p < NP; p++) begin
            data_r[p*RW +: RW]     = RW'($urandom_range(20, 0) * 100);
            data_theta[p*TW +: TW] = TW'($urandom);
         end
         tick();
      end
      ctrl_enable = 1'b1;
      idle(4);
      check_stats();
      chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
